// File: rtl/vx_retire_counter.sv
// ----------------------------------------------------------------------------
// vx_retire_counter
//
// Receives the commit-to-CSR stream and keeps the retired-instruction count
// (minstret), the cycle count (mcycle) and the counter-inhibit register
// (mcountinhibit). It also serves CSR reads and writes to these registers.
//
// Optional feature: define RETIRE_PEAK_EN to add commit statistics.
//   peak          - largest cmt_size seen with cmt_valid      (read 0xCC0)
//   active_cycles - cycles with cmt_valid && cmt_size != 0    (read 0xCC1/0xCC2)
// Without the macro these registers do not exist, and 0xCC0-0xCC2 are unowned.
//
// Ports
//   clk           core clock
//   reset         synchronous, active-high reset
//   cmt_valid     commit-to-CSR valid, registered upstream, never stalled
//   cmt_size      number of thread-instructions retired this cycle
//   csr_wr_valid  CSR write strobe
//   csr_wr_addr   CSR write address
//   csr_wr_data   CSR write data
//   csr_rd_addr   CSR read address
//   csr_rd_data   read data, combinational from registered state
//   csr_rd_hit    high when csr_rd_addr belongs to this block
//   minstret      current retired-instruction count
//   mcycle        current cycle count
// ----------------------------------------------------------------------------
module vx_retire_counter #(
    parameter int NUM_THREADS = 4,
    parameter int NUM_UNITS   = 6,
    parameter int CMT_SIZEW   = $clog2(NUM_UNITS * NUM_THREADS + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmt_valid,
    input  logic [CMT_SIZEW-1:0] cmt_size,
    input  logic                 csr_wr_valid,
    input  logic [11:0]          csr_wr_addr,
    input  logic [31:0]          csr_wr_data,
    input  logic [11:0]          csr_rd_addr,
    output logic [31:0]          csr_rd_data,
    output logic                 csr_rd_hit,
    output logic [63:0]          minstret,
    output logic [63:0]          mcycle
);

    localparam logic [11:0] ADDR_MCOUNTINHIBIT = 12'h320;
    localparam logic [11:0] ADDR_MCYCLE        = 12'hB00;
    localparam logic [11:0] ADDR_MCYCLEH       = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRET      = 12'hB02;
    localparam logic [11:0] ADDR_MINSTRETH     = 12'hB82;
    localparam logic [11:0] ADDR_CYCLE         = 12'hC00;
    localparam logic [11:0] ADDR_CYCLEH        = 12'hC80;
    localparam logic [11:0] ADDR_INSTRET       = 12'hC02;
    localparam logic [11:0] ADDR_INSTRETH      = 12'hC82;
`ifdef RETIRE_PEAK_EN
    localparam logic [11:0] ADDR_PEAK          = 12'hCC0;
    localparam logic [11:0] ADDR_ACTIVE        = 12'hCC1;
    localparam logic [11:0] ADDR_ACTIVEH       = 12'hCC2;
`endif

    logic        inhibit_cy;
    logic        inhibit_ir;
    logic        wr_inhibit;
    logic        wr_mcycle_lo;
    logic        wr_mcycle_hi;
    logic        wr_minstret_lo;
    logic        wr_minstret_hi;
    logic        retire_en;
    logic [63:0] cmt_size_ext;

    // Write decode. The read-only shadows (0xC00 etc.) are not decoded here,
    // so writes to them are dropped.
    assign wr_inhibit     = csr_wr_valid && (csr_wr_addr == ADDR_MCOUNTINHIBIT);
    assign wr_mcycle_lo   = csr_wr_valid && (csr_wr_addr == ADDR_MCYCLE);
    assign wr_mcycle_hi   = csr_wr_valid && (csr_wr_addr == ADDR_MCYCLEH);
    assign wr_minstret_lo = csr_wr_valid && (csr_wr_addr == ADDR_MINSTRET);
    assign wr_minstret_hi = csr_wr_valid && (csr_wr_addr == ADDR_MINSTRETH);

    // Inhibit bits take effect from the registered value, so a write to
    // mcountinhibit influences counting only from the following cycle.
    assign retire_en    = cmt_valid && !inhibit_ir;
    assign cmt_size_ext = {{(64 - CMT_SIZEW){1'b0}}, cmt_size};

    // Only CY (bit 0) and IR (bit 2) are implemented.
    always_ff @(posedge clk) begin
        if (reset) begin
            inhibit_cy <= 1'b0;
            inhibit_ir <= 1'b0;
        end else if (wr_inhibit) begin
            inhibit_cy <= csr_wr_data[0];
            inhibit_ir <= csr_wr_data[2];
        end
    end

    // A half-write replaces only that half; the other half keeps its old
    // value with no carry, and the cycle's increment is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            minstret <= 64'd0;
        end else if (wr_minstret_lo || wr_minstret_hi) begin
            if (wr_minstret_lo) begin
                minstret[31:0] <= csr_wr_data;
            end
            if (wr_minstret_hi) begin
                minstret[63:32] <= csr_wr_data;
            end
        end else if (retire_en) begin
            minstret <= minstret + cmt_size_ext;
        end
    end

    // Same write-wins rule for the cycle counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            mcycle <= 64'd0;
        end else if (wr_mcycle_lo || wr_mcycle_hi) begin
            if (wr_mcycle_lo) begin
                mcycle[31:0] <= csr_wr_data;
            end
            if (wr_mcycle_hi) begin
                mcycle[63:32] <= csr_wr_data;
            end
        end else if (!inhibit_cy) begin
            mcycle <= mcycle + 64'd1;
        end
    end

`ifdef RETIRE_PEAK_EN
    logic [CMT_SIZEW-1:0] peak;
    logic [63:0]          active_cycles;

    // Statistics follow the IR inhibit bit like minstret does.
    always_ff @(posedge clk) begin
        if (reset) begin
            peak          <= '0;
            active_cycles <= 64'd0;
        end else if (retire_en) begin
            if (cmt_size > peak) begin
                peak <= cmt_size;
            end
            if (cmt_size != '0) begin
                active_cycles <= active_cycles + 64'd1;
            end
        end
    end
`endif

    // Read mux. Unowned addresses return zero with hit low.
    always_comb begin
        csr_rd_data = 32'd0;
        csr_rd_hit  = 1'b0;
        case (csr_rd_addr)
            ADDR_MCOUNTINHIBIT: begin
                csr_rd_data = {29'd0, inhibit_ir, 1'b0, inhibit_cy};
                csr_rd_hit  = 1'b1;
            end
            ADDR_MCYCLE, ADDR_CYCLE: begin
                csr_rd_data = mcycle[31:0];
                csr_rd_hit  = 1'b1;
            end
            ADDR_MCYCLEH, ADDR_CYCLEH: begin
                csr_rd_data = mcycle[63:32];
                csr_rd_hit  = 1'b1;
            end
            ADDR_MINSTRET, ADDR_INSTRET: begin
                csr_rd_data = minstret[31:0];
                csr_rd_hit  = 1'b1;
            end
            ADDR_MINSTRETH, ADDR_INSTRETH: begin
                csr_rd_data = minstret[63:32];
                csr_rd_hit  = 1'b1;
            end
`ifdef RETIRE_PEAK_EN
            ADDR_PEAK: begin
                csr_rd_data = {{(32 - CMT_SIZEW){1'b0}}, peak};
                csr_rd_hit  = 1'b1;
            end
            ADDR_ACTIVE: begin
                csr_rd_data = active_cycles[31:0];
                csr_rd_hit  = 1'b1;
            end
            ADDR_ACTIVEH: begin
                csr_rd_data = active_cycles[63:32];
                csr_rd_hit  = 1'b1;
            end
`endif
            default: begin
                csr_rd_data = 32'd0;
                csr_rd_hit  = 1'b0;
            end
        endcase
    end

endmodule
